bpu: RTL and testbench

Branch prediction unit inside instruction fetch: a direct-mapped bimodal branch history table (BHT) of 2-bit saturating counters plus a tagged branch target buffer (BTB). It answers one fetch prediction request per cycle with 1-cycle latency. It also consumes the registered branch-resolution stream from the integer pipeline (`ip_if_branch*`, `ip_if_pc_override`, `ip_if_new_pc`) to train both tables. It is the fetch-side source of the `bp`/`bt` values that travel with each instruction to issue.

---
 rtl/bpu_pkg.sv | 20 ++
 rtl/bp_ram.sv | 26 ++
 rtl/bpu.sv | 160 ++++++++++++++++
 tb/tb_bpu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types for the branch prediction unit: 2-bit counter encodings,
// clear/run state encoding and the saturating counter step.
package bpu_pkg;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } bp_state_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == BP_ST) ? BP_ST : ctr + 2'd1;
    else       return (ctr == BP_SNT) ? BP_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_ram.sv
// Simple dual-port table: registered read port, one write port. wr_old exposes
// the current contents at wr_addr so callers can read-modify-write in one cycle.
module bp_ram #(
  parameter int AW = 6,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] wr_old
);

  logic [DW-1:0] mem [2**AW];

  // Read and write share one edge, so a same-address read returns the old word.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign wr_old = mem[wr_addr];

endmodule

// File: rtl/bpu.sv
// Bimodal BHT + tagged BTB fetch predictor, 1-cycle latency, no backpressure.
// Define BPU_BYPASS_EN to forward same-cycle training into the prediction.
module bpu
  import bpu_pkg::*;
#(
  parameter int BHT_ABITS = 6,
  parameter int BTB_ABITS = 5,
  parameter int TAG_BITS  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] if_bp_pc,
  input  logic        if_bp_req,
  output logic        bp_ready,
  output logic        bp_if_valid,
  output logic        bp_if_taken,
  output logic [63:0] bp_if_target,
  input  logic        ip_if_branch,
  input  logic        ip_if_branch_taken,
  input  logic [63:0] ip_if_branch_pc,
  input  logic        ip_if_pc_override,
  input  logic [63:0] ip_if_new_pc
);

  localparam int CLR_ABITS = (BHT_ABITS > BTB_ABITS) ? BHT_ABITS : BTB_ABITS;
  localparam int BTB_W     = 1 + TAG_BITS + 64;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [63:0]         target;
  } btb_entry_t;

  bp_state_t            state, state_nxt;
  logic [CLR_ABITS-1:0] clr_idx, clr_idx_nxt;
  logic                 clearing;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    clearing    = 1'b0;
    bp_ready    = 1'b0;
    case (state)
      CLEAR: begin
        clearing    = 1'b1;
        clr_idx_nxt = clr_idx + CLR_ABITS'(1);
        if (&clr_idx) state_nxt = RUN;
      end
      RUN:     bp_ready = 1'b1;
      default: state_nxt = CLEAR;
    endcase
  end

  logic [BHT_ABITS-1:0] req_bht_idx, upd_bht_idx, bht_waddr;
  logic [BTB_ABITS-1:0] req_btb_idx, upd_btb_idx, btb_waddr;
  logic [1:0]           bht_rd, bht_old, bht_wdata;
  logic                 bht_we, btb_we, upd;
  logic [BTB_W-1:0]     btb_rd_raw, btb_old;
  btb_entry_t           upd_entry, btb_wdata;

  assign req_bht_idx = if_bp_pc[BHT_ABITS+1:2];
  assign req_btb_idx = if_bp_pc[BTB_ABITS+1:2];
  assign upd_bht_idx = ip_if_branch_pc[BHT_ABITS+1:2];
  assign upd_btb_idx = ip_if_branch_pc[BTB_ABITS+1:2];
  assign upd         = ip_if_branch && bp_ready;

  assign upd_entry = '{valid: 1'b1,
                       tag: ip_if_branch_pc[BTB_ABITS+2 +: TAG_BITS],
                       target: ip_if_new_pc};

  assign bht_we    = clearing || upd;
  assign bht_waddr = clearing ? clr_idx[BHT_ABITS-1:0] : upd_bht_idx;
  assign bht_wdata = clearing ? BP_WNT : ctr_next(bht_old, ip_if_branch_taken);

  // Retraining an identical BTB entry is skipped to avoid needless writes.
  assign btb_we    = clearing || (upd && ip_if_branch_taken && (btb_old != upd_entry));
  assign btb_waddr = clearing ? clr_idx[BTB_ABITS-1:0] : upd_btb_idx;
  assign btb_wdata = clearing ? '0 : upd_entry;

  bp_ram #(.AW(BHT_ABITS), .DW(2)) u_bht (
    .clk     (clk),
    .rd_addr (req_bht_idx),
    .rd_data (bht_rd),
    .wr_en   (bht_we),
    .wr_addr (bht_waddr),
    .wr_data (bht_wdata),
    .wr_old  (bht_old)
  );

  bp_ram #(.AW(BTB_ABITS), .DW(BTB_W)) u_btb (
    .clk     (clk),
    .rd_addr (req_btb_idx),
    .rd_data (btb_rd_raw),
    .wr_en   (btb_we),
    .wr_addr (btb_waddr),
    .wr_data (btb_wdata),
    .wr_old  (btb_old)
  );

  logic        rsp_vld;
  logic [63:0] rsp_pc;

  // A redirect in the request cycle means the request PC was on the wrong path.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld <= 1'b0;
      rsp_pc  <= '0;
    end else begin
      rsp_vld <= if_bp_req && bp_ready && !ip_if_pc_override;
      rsp_pc  <= if_bp_pc;
    end
  end

  logic [1:0] ctr;
  btb_entry_t entry;

`ifdef BPU_BYPASS_EN
  logic       bht_fwd, btb_fwd;
  logic [1:0] bht_fwd_ctr;
  btb_entry_t btb_fwd_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      bht_fwd       <= 1'b0;
      btb_fwd       <= 1'b0;
      bht_fwd_ctr   <= BP_WNT;
      btb_fwd_entry <= '0;
    end else begin
      bht_fwd       <= upd && (upd_bht_idx == req_bht_idx);
      btb_fwd       <= upd && ip_if_branch_taken && (upd_btb_idx == req_btb_idx);
      bht_fwd_ctr   <= bht_wdata;
      btb_fwd_entry <= upd_entry;
    end
  end

  assign ctr   = bht_fwd ? bht_fwd_ctr : bht_rd;
  assign entry = btb_fwd ? btb_fwd_entry : btb_entry_t'(btb_rd_raw);
`else
  assign ctr   = bht_rd;
  assign entry = btb_entry_t'(btb_rd_raw);
`endif

  logic hit;
  assign hit          = entry.valid && (entry.tag == rsp_pc[BTB_ABITS+2 +: TAG_BITS]);
  assign bp_if_valid  = rsp_vld;
  assign bp_if_taken  = rsp_vld && hit && ctr[1];
  assign bp_if_target = !rsp_vld   ? 64'd0 :
                        bp_if_taken ? entry.target : rsp_pc + 64'd4;

endmodule

// File: tb/tb_bpu.sv
// Directed + random bench for bpu against a table-level model of the predictor.
module tb_bpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] if_bp_pc = '0;
  logic        if_bp_req = 1'b0;
  logic        bp_ready, bp_if_valid, bp_if_taken;
  logic [63:0] bp_if_target;
  logic        ip_if_branch = 1'b0;
  logic        ip_if_branch_taken = 1'b0;
  logic [63:0] ip_if_branch_pc = '0;
  logic        ip_if_pc_override = 1'b0;
  logic [63:0] ip_if_new_pc = '0;

  always #5 clk = ~clk;

  bpu dut (
    .clk                (clk),
    .rst                (rst),
    .if_bp_pc           (if_bp_pc),
    .if_bp_req          (if_bp_req),
    .bp_ready           (bp_ready),
    .bp_if_valid        (bp_if_valid),
    .bp_if_taken        (bp_if_taken),
    .bp_if_target       (bp_if_target),
    .ip_if_branch       (ip_if_branch),
    .ip_if_branch_taken (ip_if_branch_taken),
    .ip_if_branch_pc    (ip_if_branch_pc),
    .ip_if_pc_override  (ip_if_pc_override),
    .ip_if_new_pc       (ip_if_new_pc)
  );

  int total = 0;
  int bad   = 0;
  int nstep = 0;

  // Model: counters 0..3 per BHT slot, BTB as valid/tag/target arrays.
  int          m_bht [64];
  bit          m_v   [32];
  logic [63:0] m_tag [32];
  logic [63:0] m_tgt [32];
  int          clr_left = 64;

  function automatic int bht_i(input logic [63:0] pc);
    return int'((pc >> 2) % 64);
  endfunction
  function automatic int btb_i(input logic [63:0] pc);
    return int'((pc >> 2) % 32);
  endfunction
  function automatic logic [63:0] tag_of(input logic [63:0] pc);
    return (pc >> 7) % 65536;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    for (int i = 0; i < 32; i++) m_v[i] = 1'b0;
    clr_left = 64;
  endtask

  task automatic model_train(input logic [63:0] bpc, input bit tk, input logic [63:0] npc);
    int h, b;
    h = bht_i(bpc);
    b = btb_i(bpc);
    if (tk) begin
      if (m_bht[h] < 3) m_bht[h] = m_bht[h] + 1;
      m_v[b]   = 1'b1;
      m_tag[b] = tag_of(bpc);
      m_tgt[b] = npc;
    end else if (m_bht[h] > 0) begin
      m_bht[h] = m_bht[h] - 1;
    end
  endtask

  task automatic predict(input logic [63:0] pc, output bit tk, output logic [63:0] tgt);
    int b;
    b   = btb_i(pc);
    tk  = m_v[b] && (m_tag[b] == tag_of(pc)) && (m_bht[bht_i(pc)] >= 2);
    tgt = tk ? m_tgt[b] : pc + 64'd4;
  endtask

  task automatic step(input bit r, input bit req, input logic [63:0] pc,
                      input bit br, input bit tk, input logic [63:0] bpc,
                      input bit ovr, input logic [63:0] npc);
    bit          ready_now, exp_v, exp_tk, exp_rdy, do_upd;
    logic [63:0] exp_tgt;
    rst                = r;
    if_bp_req          = req;
    if_bp_pc           = pc;
    ip_if_branch       = br;
    ip_if_branch_taken = tk;
    ip_if_branch_pc    = bpc;
    ip_if_pc_override  = ovr;
    ip_if_new_pc       = npc;
    ready_now = (clr_left == 0);
    exp_v     = !r && req && ready_now && !ovr;
    do_upd    = !r && br && ready_now;
`ifdef BPU_BYPASS_EN
    if (do_upd) model_train(bpc, tk, npc);
    predict(pc, exp_tk, exp_tgt);
`else
    predict(pc, exp_tk, exp_tgt);
    if (do_upd) model_train(bpc, tk, npc);
`endif
    if (r) model_clear();
    else if (clr_left > 0) clr_left = clr_left - 1;
    exp_rdy = (clr_left == 0);
    nstep++;
    @(posedge clk);
    #1;
    total++;
    assert (bp_ready === exp_rdy) else begin
      bad++;
      $error("FAIL ready step=%0d got=%0b want=%0b", nstep, bp_ready, exp_rdy);
    end
    total++;
    assert (bp_if_valid === exp_v) else begin
      bad++;
      $error("FAIL valid step=%0d got=%0b want=%0b", nstep, bp_if_valid, exp_v);
    end
    if (exp_v || r) begin
      if (!exp_v) begin
        exp_tk  = 1'b0;
        exp_tgt = '0;
      end
      total++;
      assert (bp_if_taken === exp_tk) else begin
        bad++;
        $error("FAIL taken step=%0d pc=%h got=%0b want=%0b", nstep, pc, bp_if_taken, exp_tk);
      end
      total++;
      assert (bp_if_target === exp_tgt) else begin
        bad++;
        $error("FAIL target step=%0d pc=%h got=%h want=%h", nstep, pc, bp_if_target, exp_tgt);
      end
    end
  endtask

  task automatic req_only(input logic [63:0] pc);
    step(0, 1, pc, 0, 0, '0, 0, '0);
  endtask

  task automatic train(input logic [63:0] bpc, input bit tk, input logic [63:0] npc);
    step(0, 0, '0, 1, tk, bpc, 0, npc);
  endtask

  initial begin
    logic [63:0] rpc, rbpc, rnpc;

    step(1, 0, '0, 0, 0, '0, 0, '0);
    step(1, 1, 64'h8000_0000, 0, 0, '0, 0, '0);
    repeat (64) req_only(64'h8000_0000);
    req_only(64'h8000_0000);

    train(64'h8000_0010, 1, 64'h8000_0100);
    train(64'h8000_0010, 1, 64'h8000_0100);
    req_only(64'h8000_0010);
    repeat (3) begin
      train(64'h8000_0010, 0, 64'h8000_0014);
      req_only(64'h8000_0010);
    end

    train(64'h8000_0010, 1, 64'h8000_0100);
    train(64'h8000_0010, 1, 64'h8000_0100);
    req_only(64'h8001_0010);
    req_only(64'h8000_0010);

    step(0, 1, 64'h8000_0020, 1, 1, 64'h8000_0020, 1, 64'h8000_0200);
    train(64'h8000_0020, 1, 64'h8000_0200);
    req_only(64'h8000_0020);

    for (int i = 0; i < 300; i++) begin
      rpc  = 64'h8000_0000 + (64'($urandom_range(0, 1)) << 16) + (64'($urandom_range(0, 40)) << 2);
      rbpc = 64'h8000_0000 + (64'($urandom_range(0, 1)) << 16) + (64'($urandom_range(0, 40)) << 2);
      rnpc = 64'($urandom) << 2;
      step(0, 1'($urandom_range(0, 1)), rpc, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), rbpc, ($urandom_range(0, 7) == 0), rnpc);
    end

    train(64'h8000_0010, 1, 64'h8000_0100);
    train(64'h8000_0010, 1, 64'h8000_0100);
    step(1, 0, '0, 0, 0, '0, 0, '0);
    repeat (20) req_only(64'h8000_0010);
    step(1, 0, '0, 0, 0, '0, 0, '0);
    repeat (64) req_only(64'h8000_0010);
    req_only(64'h8000_0010);
    req_only(64'h8000_0044);
    step(0, 1, 64'h8000_0010, 1, 1, 64'h8000_0010, 0, 64'h8000_0300);
    req_only(64'h8000_0010);
    step(0, 1, 64'h8000_0010, 1, 1, 64'h8000_0010, 0, 64'h8000_0300);
    req_only(64'h8000_0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
